// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder and the MEM stage.
//   MEMREAD / MEMWRITE : bit positions inside the 2-bit mem_ctrl request
//   dmem_state_t       : responder state (CLEAR while sweeping, READY while serving)
//   DMEM_DEPTH         : default number of 32-bit words
package data_mem_responder_pkg;

  localparam int unsigned MEMREAD    = 1;
  localparam int unsigned MEMWRITE   = 0;
  localparam int unsigned DMEM_DEPTH = 256;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/dmem_sat_counter.sv
// Saturating up-counter used for the load/store statistics.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset, clears the count
//   i_inc   : increment request for this cycle
//   o_count : current count, holds at all-ones instead of wrapping
module dmem_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with zero-latency reads, an initial clear sweep,
// sticky illegal-access flag and saturating load/store counters.
//   clk       : clock, all state on rising edge
//   reset_n   : synchronous active-low reset, restarts the clear sweep
//   mem_ctrl  : [1]=memread, [0]=memwrite
//   address   : byte address
//   w_data    : store data
//   read_data : combinational load data (0 unless a legal load in READY)
//   ready     : memory is serving requests
//   fault     : sticky illegal-access flag
//   rd_count  : accepted loads, saturating
//   wr_count  : accepted stores, saturating
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int unsigned IDX_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_ctrl,
  input  logic [31:0] address,
  input  logic [31:0] w_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        fault,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dmem_state_t      r_state;
  logic [IDX_W-1:0] r_clr_ptr;
  logic             r_fault;
  logic [31:0]      r_mem [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic             w_req;
  logic             w_illegal;
  logic             w_serving;
  logic             w_load;
  logic             w_store;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [31:0]      w_wdata;

  assign w_idx     = address[IDX_W+1:2];
  assign w_req     = |mem_ctrl;
  // Misaligned, beyond the array, or both read and write requested at once.
  assign w_illegal = w_req & ((|address[1:0])
                            | (|(address >> (IDX_W + 2)))
                            | (mem_ctrl[MEMREAD] & mem_ctrl[MEMWRITE]));
  assign w_serving = (r_state == READY);
  assign w_load    = w_serving & mem_ctrl[MEMREAD]  & ~w_illegal;
  assign w_store   = w_serving & mem_ctrl[MEMWRITE] & ~w_illegal;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_fault   <= 1'b0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + IDX_W'(1);
          if (r_clr_ptr == LAST_IDX) begin
            r_state <= READY;
          end
        end
        READY: begin
          if (w_illegal) begin
            r_fault <= 1'b1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Single write port shared by the clear sweep and accepted stores; the two
  // never overlap because stores are only accepted in READY.
  assign w_we    = reset_n & ((r_state == CLEAR) | w_store);
  assign w_waddr = (r_state == CLEAR) ? r_clr_ptr : w_idx;
  assign w_wdata = (r_state == CLEAR) ? '0 : w_data;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign read_data = w_load ? r_mem[w_idx] : '0;
  assign ready     = w_serving;
  assign fault     = r_fault;

  dmem_sat_counter #(.WIDTH(32)) u_rd_count (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_inc   (w_load),
    .o_count (rd_count)
  );

  dmem_sat_counter #(.WIDTH(32)) u_wr_count (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_inc   (w_store),
    .o_count (wr_count)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int IDX_W = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_ctrl;
  logic [31:0] address;
  logic [31:0] w_data;
  logic [31:0] read_data;
  logic        ready;
  logic        fault;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_ctrl  (mem_ctrl),
    .address   (address),
    .w_data    (w_data),
    .read_data (read_data),
    .ready     (ready),
    .fault     (fault),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  // Narrow standalone counter so saturation is reachable in a short run.
  logic       s_rst_n;
  logic       s_inc;
  logic [3:0] s_cnt;

  dmem_sat_counter #(.WIDTH(4)) u_sat (
    .i_clk   (clk),
    .i_rst_n (s_rst_n),
    .i_inc   (s_inc),
    .o_count (s_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image, remaining sweep cycles, flags and counts.
  logic [31:0] m_mem [DEPTH];
  int          m_clear_left;
  bit          m_fault;
  longint      m_rd;
  longint      m_wr;

  function automatic bit is_illegal(input logic [1:0] ctrl, input logic [31:0] addr);
    return (ctrl == 2'b11) || ((addr % 4) != 0) || (addr >= 32'(DEPTH * 4));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle and compare all outputs against the model.
  task automatic drive(input logic rst, input logic [1:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp_rd;
    bit          m_ready;
    reset_n  = rst;
    mem_ctrl = ctrl;
    address  = addr;
    w_data   = data;
    #1;
    m_ready = (m_clear_left == 0);
    exp_rd  = '0;
    if (m_ready && ctrl == 2'b10 && !is_illegal(ctrl, addr))
      exp_rd = m_mem[int'(addr >> 2)];
    check("ready",     {31'b0, ready}, {31'b0, m_ready});
    check("fault",     {31'b0, fault}, {31'b0, m_fault});
    check("read_data", read_data, exp_rd);
    check("rd_count",  rd_count, 32'(m_rd));
    check("wr_count",  wr_count, 32'(m_wr));
  endtask

  // Advance one clock edge and apply the same cycle to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      m_clear_left = DEPTH;
      m_fault      = 0;
      m_rd         = 0;
      m_wr         = 0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0)
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (mem_ctrl != 2'b00) begin
      if (is_illegal(mem_ctrl, address)) begin
        m_fault = 1;
      end else if (mem_ctrl == 2'b10) begin
        if (m_rd < 64'hFFFF_FFFF) m_rd++;
      end else begin
        if (m_wr < 64'hFFFF_FFFF) m_wr++;
        m_mem[int'(address >> 2)] = w_data;
      end
    end
    #1;
  endtask

  task automatic step(input logic rst, input logic [1:0] ctrl,
                      input logic [31:0] addr, input logic [31:0] data);
    drive(rst, ctrl, addr, data);
    tick();
  endtask

  // One reset cycle, then the full sweep; optional store at a given sweep cycle.
  task automatic reset_and_sweep(input int store_at);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == store_at) drive(1'b1, 2'b01, 32'h40, 32'hA5A5A5A5);
      else               drive(1'b1, 2'b00, 32'h0, 32'h0);
      check("sweep_ready_low", {31'b0, ready}, 32'h0);
      tick();
    end
    drive(1'b1, 2'b00, 32'h0, 32'h0);
    check("ready_after_sweep", {31'b0, ready}, 32'h1);
  endtask

  initial begin
    logic [1:0]  r_ctrl;
    logic [31:0] r_addr;
    int          sel;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    reset_n  = 1'b0;
    mem_ctrl = 2'b00;
    address  = '0;
    w_data   = '0;
    s_rst_n  = 1'b0;
    s_inc    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_clear_left = DEPTH;
    m_fault      = 0;
    m_rd         = 0;
    m_wr         = 0;

    // Reset state
    drive(1'b0, 2'b10, 32'h0, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_rdcnt", rd_count, 32'h0);
    check("rst_wrcnt", wr_count, 32'h0);
    check("rst_rdata", read_data, 32'h0);
    tick();

    // Sweep timing, cleared words, store dropped during CLEAR cycle 10
    reset_and_sweep(10);
    tick();
    drive(1'b1, 2'b10, 32'h000, 32'h0); check("ld_000", read_data, 32'h0); tick();
    drive(1'b1, 2'b10, 32'h200, 32'h0); check("ld_200", read_data, 32'h0); tick();
    drive(1'b1, 2'b10, 32'h3FC, 32'h0); check("ld_3FC", read_data, 32'h0); tick();
    drive(1'b1, 2'b10, 32'h040, 32'h0); check("ld_040_clear_store", read_data, 32'h0); tick();
    drive(1'b1, 2'b00, 32'h0, 32'h0);
    check("rdcnt_4", rd_count, 32'd4);
    check("wrcnt_0", wr_count, 32'd0);
    tick();

    // Misaligned store, out-of-range load, read+write together
    reset_and_sweep(-1);
    tick();
    step(1'b1, 2'b01, 32'h13, 32'h12345678);
    drive(1'b1, 2'b10, 32'h10, 32'h0);
    check("misalign_fault", {31'b0, fault}, 32'h1);
    check("word4_unwritten", read_data, 32'h0);
    check("misalign_wrcnt", wr_count, 32'h0);
    tick();
    drive(1'b1, 2'b10, 32'h400, 32'h0);
    check("oor_rdata", read_data, 32'h0);
    check("oor_fault", {31'b0, fault}, 32'h1);
    tick();
    drive(1'b1, 2'b11, 32'h20, 32'hCAFEF00D);
    check("both_rdata", read_data, 32'h0);
    tick();
    drive(1'b1, 2'b10, 32'h20, 32'h0);
    check("both_nowrite", read_data, 32'h0);
    check("both_rdcnt", rd_count, 32'd1);
    check("both_wrcnt", wr_count, 32'd0);
    tick();

    // Store then immediate load of the same word
    reset_and_sweep(-1);
    tick();
    step(1'b1, 2'b01, 32'h10, 32'hDEADBEEF);
    drive(1'b1, 2'b10, 32'h10, 32'h0);
    check("st_ld_rdata", read_data, 32'hDEADBEEF);
    tick();
    drive(1'b1, 2'b00, 32'h0, 32'h0);
    check("st_ld_wrcnt", wr_count, 32'd1);
    check("st_ld_rdcnt", rd_count, 32'd1);
    check("st_ld_fault", {31'b0, fault}, 32'h0);
    tick();

    // Reset mid-sweep restarts the full clear
    step(1'b1, 2'b01, 32'h0F0, 32'h5555AAAA);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 100; i++) step(1'b1, 2'b00, 32'h0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 2'b00, 32'h0, 32'h0);
    check("midrst_ready", {31'b0, ready}, 32'h0);
    check("midrst_fault", {31'b0, fault}, 32'h0);
    check("midrst_rdcnt", rd_count, 32'h0);
    check("midrst_wrcnt", wr_count, 32'h0);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b1, 2'b00, 32'h0, 32'h0);
      check("midrst_sweep_low", {31'b0, ready}, 32'h0);
      tick();
    end
    drive(1'b1, 2'b10, 32'h0F0, 32'h0);
    check("midrst_ready_back", {31'b0, ready}, 32'h1);
    check("midrst_word_cleared", read_data, 32'h0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sel    = int'($urandom_range(0, 99));
      r_ctrl = 2'($urandom_range(0, 2));
      r_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (sel < 2)      r_addr = $urandom();
      else if (sel < 4) r_addr = r_addr | 32'($urandom_range(1, 3));
      else if (sel < 5) r_ctrl = 2'b11;
      if (sel == 99 && $urandom_range(0, 3) == 0)
        step(1'b0, r_ctrl, r_addr, $urandom());
      else
        step(1'b1, r_ctrl, r_addr, $urandom());
    end

    // Saturation of a narrow counter instance
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    s_inc   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check("sat_count", 32'(s_cnt), 32'((k > 15) ? 15 : k));
    end
    s_inc = 1'b0;
    @(posedge clk); #1;
    check("sat_hold", 32'(s_cnt), 32'd15);
    s_rst_n = 1'b0;
    @(posedge clk); #1;
    check("sat_reset", 32'(s_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
